// File: rtl/vending_machine_multi_if.sv
// Bus between a vending controller and its front panel / coin mechanism.
// master : drives coin, sel_valid, sel, cancel, refill; observes the status outputs
// slave  : the controller; consumes the requests and drives out, item, chg_coin,
//          coin_rej, err, credit, busy
interface vending_machine_multi_if #(
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned CREDIT_W = 8
);
  logic [1:0]          coin;
  logic                sel_valid;
  logic [SEL_W-1:0]    sel;
  logic                cancel;
  logic                refill;
  logic                out;
  logic [SEL_W-1:0]    item;
  logic [1:0]          chg_coin;
  logic                coin_rej;
  logic                err;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin, sel_valid, sel, cancel, refill,
    input  out, item, chg_coin, coin_rej, err, credit, busy
  );

  modport slave (
    input  coin, sel_valid, sel, cancel, refill,
    output out, item, chg_coin, coin_rej, err, credit, busy
  );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: three coin denominations, per-item prices
// and stock, cancel/refund, and greedy one-coin-per-cycle change payout.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (forfeits credit, reloads stock)
//   bus  - vending_machine_multi_if.slave; requests in (coin, sel_valid, sel,
//          cancel, refill), registered status out (out, item, chg_coin,
//          coin_rej, err, credit, busy)
module vending_machine_multi #(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 3,
  parameter int unsigned COIN1      = 5,
  parameter int unsigned COIN2      = 10,
  parameter int unsigned COIN3      = 25,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd40, 8'd25, 8'd20, 8'd15},
  parameter int unsigned MAX_CREDIT = 95
) (
  input  logic clk,
  input  logic rst,
  vending_machine_multi_if.slave bus
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] VEND   = 2'd1;
  localparam logic [1:0] CHANGE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
  logic                out_q, out_d;
  logic [SEL_W-1:0]    item_q, item_d;
  logic [1:0]          chg_q, chg_d;
  logic                rej_q, rej_d;
  logic                err_q, err_d;

  logic [SUM_W-1:0]    sum;
  logic [CREDIT_W-1:0] price;
  logic                sel_ok;
  logic                coin_in;

  // Value of a coin code.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   coin_value = CREDIT_W'(COIN1);
      2'b10:   coin_value = CREDIT_W'(COIN2);
      2'b11:   coin_value = CREDIT_W'(COIN3);
      default: coin_value = '0;
    endcase
  endfunction

  // Largest coin not exceeding the remaining credit.
  function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(COIN3))      pick_coin = 2'b11;
    else if (c >= CREDIT_W'(COIN2)) pick_coin = 2'b10;
    else if (c >= CREDIT_W'(COIN1)) pick_coin = 2'b01;
    else                            pick_coin = 2'b00;
  endfunction

  assign coin_in = (bus.coin != 2'b00);
  assign sum     = {1'b0, credit_q} + {1'b0, coin_value(bus.coin)};
  assign price   = PRICES[32'(bus.sel)*CREDIT_W +: CREDIT_W];
  assign sel_ok  = (32'(bus.sel) < NUM_ITEMS);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      out_q    <= 1'b0;
      item_q   <= '0;
      chg_q    <= 2'b00;
      rej_q    <= 1'b0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      out_q    <= out_d;
      item_q   <= item_d;
      chg_q    <= chg_d;
      rej_q    <= rej_d;
      err_q    <= err_d;
      stock_q  <= stock_d;
    end
  end

  // Next state and next output values.
  // chg_d is the coin shown during the coming CHANGE cycle; credit keeps the
  // amount still owed before that coin and drops on the edge ending the cycle.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    out_d    = 1'b0;
    item_d   = item_q;
    chg_d    = 2'b00;
    rej_d    = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cancel && credit_q != '0) begin
          state_d = CHANGE;
          chg_d   = pick_coin(credit_q);
          rej_d   = coin_in;
        end else if (bus.sel_valid) begin
          // A selection owns the cycle even when refused, so a coin is returned.
          rej_d = coin_in;
          if (!sel_ok || stock_q[bus.sel] == '0 || credit_q < price) begin
            err_d = 1'b1;
          end else begin
            state_d              = VEND;
            credit_d             = credit_q - price;
            stock_d[bus.sel]     = stock_q[bus.sel] - STOCK_W'(1);
            out_d                = 1'b1;
            item_d               = bus.sel;
          end
        end else if (coin_in) begin
          if (sum <= SUM_W'(MAX_CREDIT)) credit_d = sum[CREDIT_W-1:0];
          else                           rej_d    = 1'b1;
        end
      end

      VEND: begin
        rej_d = coin_in;
        if (credit_q != '0) begin
          state_d = CHANGE;
          chg_d   = pick_coin(credit_q);
        end else begin
          state_d = IDLE;
        end
      end

      CHANGE: begin
        rej_d    = coin_in;
        credit_d = credit_q - coin_value(pick_coin(credit_q));
        if (credit_d == '0) state_d = IDLE;
        else                chg_d   = pick_coin(credit_d);
      end

      default: state_d = IDLE;
    endcase

    // Refill wins over a same-cycle vend decrement.
    if (bus.refill) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
    end
  end

  assign bus.out      = out_q;
  assign bus.item     = item_q;
  assign bus.chg_coin = chg_q;
  assign bus.coin_rej = rej_q;
  assign bus.err      = err_q;
  assign bus.credit   = credit_q;
  assign bus.busy     = (state_q != IDLE);

endmodule
